mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multicycle MIPS control unit. It is the producer side of the 4-bit ALU control interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath enables and mux selects every cycle, and drives the ALU operation code from the shared ALU control package.
- Consumes the ALU zero flag for branches, and a memory ready handshake for fetch and load/store stalls.

Parameters:
- RESET_STATE, FETCH, state entered on leaving reset.
- ILLEGAL_HALT, 1, if 1 an illegal opcode/funct parks the FSM in HALT; if 0 it is treated as a NOP and the FSM returns to FETCH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register; valid from DECODE onward.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag; sampled in BRANCH.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- alu_ctl  out  4  ALU operation code, AluCtrlSig_pkg encoding.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by zero (BEQ).
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write data source: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A source: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B source: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal  out  1  pulses for one cycle on an undecodable instruction.

Behaviour:
- Reset (async, rst_n low): state = FETCH; all enables 0, all selects 0, alu_ctl = ADD, illegal = 0. Outputs are Moore: a function of state, plus opcode/funct in EXEC.
- FETCH:
  - Asserts mem_read, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_ctl = ADD, pc_src = 00.
  - ir_write and pc_write are asserted only in the cycle mem_ready = 1; the FSM holds in FETCH otherwise.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_ctl = ADD (branch target precompute). Next state by opcode:
  - LW/SW -> MEMADR; R-type -> EXEC; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP; other -> ILLEGAL.
- MEMADR: alu_src_a = 1, alu_src_b = 10, ADD. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_read, iord = 1; holds until mem_ready, then -> MEMWB.
- MEMWB: reg_write, mem_to_reg = 1, reg_dst = 0 -> FETCH.
- MEMWR: mem_write, iord = 1; holds until mem_ready, then -> FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_ctl from funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT.
  - Any other funct -> ILLEGAL.
  - -> ALUWB.
- ALUWB: reg_write, reg_dst = 1, mem_to_reg = 0 -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, SUB, pc_write_cond = 1, pc_src = 01 -> FETCH. The PC update itself is the datapath AND with zero.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, ADD -> ADDIWB.
- ADDIWB: reg_write, reg_dst = 0 -> FETCH.
- JUMP: pc_write, pc_src = 10 -> FETCH.
- ILLEGAL: illegal = 1 for one cycle; then -> HALT if ILLEGAL_HALT, else -> FETCH.
- HALT: all enables 0; leaves only on reset.
- Boundary conditions:
  - mem_write and reg_write are never both high in one cycle.
  - alu_ctl in non-ALU states holds ADD; it is never an undefined code.
  - A mem_ready high outside FETCH/MEMRD/MEMWR is ignored.
  - Reset asserted mid-instruction drops all enables in the same cycle, with no partial writeback.
- Latency (mem_ready = 1 immediately): R-type 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3 cycles.

Decomposition:
- AluCtrlSig_pkg holds the ALU codes:
  - AND = 0000, OR = 0001, ADD = 0010, XOR = 0011, SUB = 0110, SLT = 0111, NOR = 1100.
- Add to the same package: the opcode constants (R = 0x00, LW = 0x23, SW = 0x2B, BEQ = 0x04, ADDI = 0x08, J = 0x02), the funct constants, and the state enum typedef.
- Sub-module alu_decoder: combinational funct -> alu_ctl plus a valid flag; instantiated for EXEC.

Test Plan:
- Reset mid-MEMRD: deassert then reassert rst_n -> state FETCH, reg_write = 0, mem_read = 1 on the first cycle after release.
- R-type funct 0x22, mem_ready held 1: FETCH, DECODE, EXEC (alu_ctl = 0110), ALUWB (reg_write = 1, reg_dst = 1) -> back to FETCH after 4 cycles. Repeat for all 7 functs, checking their codes.
- LW with mem_ready low for 3 cycles in MEMRD: FSM holds, mem_read = 1, iord = 1; on mem_ready go to MEMWB with mem_to_reg = 1 -> total 8 cycles.
- BEQ: pc_write_cond = 1, pc_src = 01, alu_ctl = 0110 in BRANCH, pc_write = 0, for both zero = 0 and zero = 1 -> 3 cycles.
- SW: mem_write = 1 only in MEMWR, reg_write never 1 across the instruction.
- Opcode 0x3F with ILLEGAL_HALT = 1: illegal pulses once, FSM stays in HALT with no enables for 20 cycles. Funct 0x00 with ILLEGAL_HALT = 0: illegal pulse, then FETCH.

Source files
------------

// File: rtl/AluCtrlSig_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU operation codes,
// opcode/funct constants, controller state set and the control-word bundle.
package AluCtrlSig_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ST_FETCH,
      ST_DECODE,
      ST_MEMADR,
      ST_MEMRD,
      ST_MEMWB,
      ST_MEMWR,
      ST_EXEC,
      ST_ALUWB,
      ST_BRANCH,
      ST_ADDIEX,
      ST_ADDIWB,
      ST_JUMP,
      ST_ILLEGAL,
      ST_HALT
   } mc_state_t;

   typedef struct packed {
      logic [3:0] alu_ctl;
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic       illegal;
   } ctl_t;

   // Quiescent control word: every enable and select low, ALU left on ADD.
   localparam ctl_t CTL_IDLE = ctl_t'({ALU_ADD, 15'd0});

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation code; valid_o drops for unsupported functs,
// in which case the code falls back to ADD so the ALU never sees an undefined op.
module alu_decoder
   import AluCtrlSig_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [3:0] alu_ctl_o,
   output logic       valid_o
);

   always_comb begin
      alu_ctl_o = ALU_ADD;
      valid_o   = 1'b1;
      case (funct_i)
         FN_ADD:  alu_ctl_o = ALU_ADD;
         FN_SUB:  alu_ctl_o = ALU_SUB;
         FN_AND:  alu_ctl_o = ALU_AND;
         FN_OR:   alu_ctl_o = ALU_OR;
         FN_XOR:  alu_ctl_o = ALU_XOR;
         FN_NOR:  alu_ctl_o = ALU_NOR;
         FN_SLT:  alu_ctl_o = ALU_SLT;
         default: valid_o   = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: steps each instruction through fetch/decode/execute/
// memory/writeback and drives the datapath control word from the current state.
module mips_mc_ctrl
   import AluCtrlSig_pkg::*;
#(
   parameter mc_state_t RESET_STATE  = ST_FETCH,
   parameter bit        ILLEGAL_HALT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [3:0] alu_ctl,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic       illegal
);

   mc_state_t  state_q, state_d;
   ctl_t       ctl;
   logic [3:0] dec_alu;
   logic       dec_valid;
   logic       unused_zero;

   // Branch qualification by zero is done in the datapath (pc_write_cond & zero).
   assign unused_zero = zero;

   alu_decoder u_alu_dec (
      .funct_i   (funct),
      .alu_ctl_o (dec_alu),
      .valid_o   (dec_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RESET_STATE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ctl     = CTL_IDLE;
      case (state_q)
         ST_FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = 2'b01;
            if (mem_ready) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
               state_d      = ST_DECODE;
            end
         end
         ST_DECODE: begin
            ctl.alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = ST_MEMADR;
               OP_RTYPE:     state_d = ST_EXEC;
               OP_BEQ:       state_d = ST_BRANCH;
               OP_ADDI:      state_d = ST_ADDIEX;
               OP_J:         state_d = ST_JUMP;
               default:      state_d = ST_ILLEGAL;
            endcase
         end
         ST_MEMADR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
            state_d       = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
         end
         ST_MEMRD: begin
            ctl.mem_read = 1'b1;
            ctl.iord     = 1'b1;
            if (mem_ready) state_d = ST_MEMWB;
         end
         ST_MEMWB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            state_d        = ST_FETCH;
         end
         ST_MEMWR: begin
            ctl.mem_write = 1'b1;
            ctl.iord      = 1'b1;
            if (mem_ready) state_d = ST_FETCH;
         end
         ST_EXEC: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_ctl   = dec_alu;
            state_d       = dec_valid ? ST_ALUWB : ST_ILLEGAL;
         end
         ST_ALUWB: begin
            ctl.reg_write = 1'b1;
            ctl.reg_dst   = 1'b1;
            state_d       = ST_FETCH;
         end
         ST_BRANCH: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_ctl       = ALU_SUB;
            ctl.pc_write_cond = 1'b1;
            ctl.pc_src        = 2'b01;
            state_d           = ST_FETCH;
         end
         ST_ADDIEX: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
            state_d       = ST_ADDIWB;
         end
         ST_ADDIWB: begin
            ctl.reg_write = 1'b1;
            state_d       = ST_FETCH;
         end
         ST_JUMP: begin
            ctl.pc_write = 1'b1;
            ctl.pc_src   = 2'b10;
            state_d      = ST_FETCH;
         end
         ST_ILLEGAL: begin
            ctl.illegal = 1'b1;
            state_d     = ILLEGAL_HALT ? ST_HALT : ST_FETCH;
         end
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_FETCH;
      endcase
      // Reset kills every enable immediately, even mid-instruction.
      if (!rst_n) ctl = CTL_IDLE;
   end

   assign alu_ctl       = ctl.alu_ctl;
   assign pc_write      = ctl.pc_write;
   assign pc_write_cond = ctl.pc_write_cond;
   assign iord          = ctl.iord;
   assign mem_read      = ctl.mem_read;
   assign mem_write     = ctl.mem_write;
   assign ir_write      = ctl.ir_write;
   assign mem_to_reg    = ctl.mem_to_reg;
   assign reg_dst       = ctl.reg_dst;
   assign reg_write     = ctl.reg_write;
   assign alu_src_a     = ctl.alu_src_a;
   assign alu_src_b     = ctl.alu_src_b;
   assign pc_src        = ctl.pc_src;
   assign illegal       = ctl.illegal;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: latency/ALU-code table, hand-written reset and illegal
// sequences, and random instruction streams checked against a per-instruction model.
module tb_mips_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0, funct = '0;
   logic       zero = 1'b0, mem_ready = 1'b0;

   logic [3:0] alu_ctl0, alu_ctl1;
   logic       pc_write0, pc_write_cond0, iord0, mem_read0, mem_write0, ir_write0;
   logic       mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, illegal0;
   logic [1:0] alu_src_b0, pc_src0;
   logic       pc_write1, pc_write_cond1, iord1, mem_read1, mem_write1, ir_write1;
   logic       mem_to_reg1, reg_dst1, reg_write1, alu_src_a1, illegal1;
   logic [1:0] alu_src_b1, pc_src1;
   logic [18:0] ov0, ov1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_mc_ctrl #(.ILLEGAL_HALT(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .alu_ctl(alu_ctl0), .pc_write(pc_write0),
      .pc_write_cond(pc_write_cond0), .iord(iord0), .mem_read(mem_read0),
      .mem_write(mem_write0), .ir_write(ir_write0), .mem_to_reg(mem_to_reg0),
      .reg_dst(reg_dst0), .reg_write(reg_write0), .alu_src_a(alu_src_a0),
      .alu_src_b(alu_src_b0), .pc_src(pc_src0), .illegal(illegal0));

   mips_mc_ctrl #(.ILLEGAL_HALT(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .alu_ctl(alu_ctl1), .pc_write(pc_write1),
      .pc_write_cond(pc_write_cond1), .iord(iord1), .mem_read(mem_read1),
      .mem_write(mem_write1), .ir_write(ir_write1), .mem_to_reg(mem_to_reg1),
      .reg_dst(reg_dst1), .reg_write(reg_write1), .alu_src_a(alu_src_a1),
      .alu_src_b(alu_src_b1), .pc_src(pc_src1), .illegal(illegal1));

   assign ov0 = {alu_ctl0, pc_write0, pc_write_cond0, iord0, mem_read0, mem_write0,
                 ir_write0, mem_to_reg0, reg_dst0, reg_write0, alu_src_a0,
                 alu_src_b0, pc_src0, illegal0};
   assign ov1 = {alu_ctl1, pc_write1, pc_write_cond1, iord1, mem_read1, mem_write1,
                 ir_write1, mem_to_reg1, reg_dst1, reg_write1, alu_src_a1,
                 alu_src_b1, pc_src1, illegal1};

   function automatic logic [18:0] ov(input logic [3:0] alu, input logic pcw, pcwc,
                                      iord, mr, mw, irw, m2r, rdst, rw, asa,
                                      input logic [1:0] asb, pcs, input logic ill);
      return {alu, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, pcs, ill};
   endfunction

   // Architectural funct table: {legal, ALU code}
   function automatic logic [4:0] ref_alu(input logic [5:0] fn);
      case (fn)
         6'h20:   return {1'b1, 4'b0010};
         6'h22:   return {1'b1, 4'b0110};
         6'h24:   return {1'b1, 4'b0000};
         6'h25:   return {1'b1, 4'b0001};
         6'h26:   return {1'b1, 4'b0011};
         6'h27:   return {1'b1, 4'b1100};
         6'h2A:   return {1'b1, 4'b0111};
         default: return {1'b0, 4'b0010};
      endcase
   endfunction

   logic [18:0] v_rst, v_fwait, v_fgo, v_dec, v_madr, v_mrd, v_mwb, v_mwr;
   logic [18:0] v_aluwb, v_beq, v_addiex, v_addiwb, v_jump, v_ill, v_halt;

   task automatic chk(input logic [18:0] act, input logic [18:0] exp, input string nm);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
      checks++;
      if (act[10] === 1'b1 && act[6] === 1'b1) begin
         errors++;
         $display("FAIL %s mem_write+reg_write both high got %h want not both", nm, act);
      end
   endtask

   task automatic step(input int sel, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [18:0] exp,
                       input string nm);
      @(negedge clk);
      opcode = op; funct = fn; zero = z; mem_ready = rdy;
      #1;
      chk(sel != 0 ? ov1 : ov0, exp, nm);
   endtask

   // Expected per-cycle control words for one instruction, derived from the ISA rules.
   task automatic run_instr(input int sel, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int sf, input int sm);
      logic [18:0] e[$];
      logic        r[$];
      logic [4:0]  a;
      for (int i = 0; i < sf; i++) begin e.push_back(v_fwait); r.push_back(1'b0); end
      e.push_back(v_fgo); r.push_back(1'b1);
      e.push_back(v_dec); r.push_back(1'($urandom));
      case (op)
         6'h23: begin
            e.push_back(v_madr); r.push_back(1'($urandom));
            for (int i = 0; i < sm; i++) begin e.push_back(v_mrd); r.push_back(1'b0); end
            e.push_back(v_mrd); r.push_back(1'b1);
            e.push_back(v_mwb); r.push_back(1'($urandom));
         end
         6'h2B: begin
            e.push_back(v_madr); r.push_back(1'($urandom));
            for (int i = 0; i < sm; i++) begin e.push_back(v_mwr); r.push_back(1'b0); end
            e.push_back(v_mwr); r.push_back(1'b1);
         end
         6'h00: begin
            a = ref_alu(fn);
            e.push_back(ov(a[3:0], 0,0,0,0,0,0,0,0,0, 1, 2'b00, 2'b00, 0));
            r.push_back(1'($urandom));
            e.push_back(a[4] ? v_aluwb : v_ill); r.push_back(1'($urandom));
         end
         6'h04: begin e.push_back(v_beq); r.push_back(1'($urandom)); end
         6'h08: begin
            e.push_back(v_addiex); r.push_back(1'($urandom));
            e.push_back(v_addiwb); r.push_back(1'($urandom));
         end
         6'h02: begin e.push_back(v_jump); r.push_back(1'($urandom)); end
         default: begin e.push_back(v_ill); r.push_back(1'($urandom)); end
      endcase
      for (int i = 0; i < e.size(); i++)
         step(sel, (i <= sf) ? 6'($urandom) : op, fn, z, r[i], e[i],
              $sformatf("dut%0d op%02h fn%02h cyc%0d", sel, op, fn, i));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; mem_ready = 1'b1;
      #1;
      chk(ov0, v_rst, "reset_dut0");
      chk(ov1, v_rst, "reset_dut1");
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b0;
   endtask

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic [15:0] rdy;
      int          lat;
      int          acyc;
      logic [3:0]  alu;
      string       nm;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      v_rst    = ov(4'b0010, 0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0);
      v_fwait  = ov(4'b0010, 0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 0);
      v_fgo    = ov(4'b0010, 1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 0);
      v_dec    = ov(4'b0010, 0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 0);
      v_madr   = ov(4'b0010, 0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 0);
      v_mrd    = ov(4'b0010, 0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 0);
      v_mwb    = ov(4'b0010, 0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 0);
      v_mwr    = ov(4'b0010, 0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 0);
      v_aluwb  = ov(4'b0010, 0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 0);
      v_beq    = ov(4'b0110, 0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 0);
      v_addiex = ov(4'b0010, 0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 0);
      v_addiwb = ov(4'b0010, 0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 0);
      v_jump   = ov(4'b0010, 1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 0);
      v_ill    = ov(4'b0010, 0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 1);
      v_halt   = v_rst;

      tbl[0]  = '{6'h00, 6'h20, 0, 16'hFFFF, 4, 2, 4'b0010, "r_add"};
      tbl[1]  = '{6'h00, 6'h22, 0, 16'hFFFF, 4, 2, 4'b0110, "r_sub"};
      tbl[2]  = '{6'h00, 6'h24, 0, 16'hFFFF, 4, 2, 4'b0000, "r_and"};
      tbl[3]  = '{6'h00, 6'h25, 0, 16'hFFFF, 4, 2, 4'b0001, "r_or"};
      tbl[4]  = '{6'h00, 6'h26, 0, 16'hFFFF, 4, 2, 4'b0011, "r_xor"};
      tbl[5]  = '{6'h00, 6'h27, 0, 16'hFFFF, 4, 2, 4'b1100, "r_nor"};
      tbl[6]  = '{6'h00, 6'h2A, 0, 16'hFFFF, 4, 2, 4'b0111, "r_slt"};
      tbl[7]  = '{6'h23, 6'h00, 0, 16'hFFFF, 5, 2, 4'b0010, "lw"};
      tbl[8]  = '{6'h23, 6'h00, 0, 16'hFFC7, 8, 4, 4'b0010, "lw_stall3"};
      tbl[9]  = '{6'h2B, 6'h00, 0, 16'hFFFF, 4, 3, 4'b0010, "sw"};
      tbl[10] = '{6'h04, 6'h00, 0, 16'hFFFF, 3, 2, 4'b0110, "beq_z0"};
      tbl[11] = '{6'h04, 6'h00, 1, 16'hFFFF, 3, 2, 4'b0110, "beq_z1"};
      tbl[12] = '{6'h08, 6'h00, 0, 16'hFFFF, 4, 2, 4'b0010, "addi"};
      tbl[13] = '{6'h02, 6'h00, 0, 16'hFFFF, 3, 2, 4'b0010, "j"};

      // Power-on reset
      #2;
      chk(ov0, v_rst, "poweron_reset");
      do_reset();

      // Latency and ALU code per instruction, measured from the DUT's return to FETCH
      foreach (tbl[k]) begin
         int lat;
         lat = -1;
         for (int c = 0; c < 30 && lat < 0; c++) begin
            @(negedge clk);
            opcode = tbl[k].op; funct = tbl[k].fn; zero = tbl[k].z;
            mem_ready = (c < 16) ? tbl[k].rdy[c] : 1'b1;
            #1;
            if (c == tbl[k].acyc) begin
               checks++;
               if (alu_ctl0 !== tbl[k].alu) begin
                  errors++;
                  $display("FAIL %s alu_ctl got %b want %b", tbl[k].nm, alu_ctl0, tbl[k].alu);
               end
            end
            if (c > 0 && mem_read0 && !iord0 && alu_src_b0 == 2'b01) begin
               lat = c;
               mem_ready = 1'b0;
            end
         end
         checks++;
         if (lat != tbl[k].lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", tbl[k].nm, lat, tbl[k].lat);
         end
      end

      // Full per-cycle words: LW with three MEMRD stalls, BEQ both ways, SW
      run_instr(0, 6'h23, 6'h00, 0, 0, 3);
      run_instr(0, 6'h04, 6'h00, 0, 0, 0);
      run_instr(0, 6'h04, 6'h00, 1, 1, 0);
      run_instr(0, 6'h2B, 6'h00, 0, 2, 2);

      // Reset while stalled in MEMRD
      step(0, 6'h23, 6'h00, 0, 1, v_fgo,  "rst_mid fetch");
      step(0, 6'h23, 6'h00, 0, 1, v_dec,  "rst_mid decode");
      step(0, 6'h23, 6'h00, 0, 1, v_madr, "rst_mid memadr");
      step(0, 6'h23, 6'h00, 0, 0, v_mrd,  "rst_mid memrd");
      @(negedge clk);
      rst_n = 1'b0; mem_ready = 1'b1;
      #1;
      chk(ov0, v_rst, "rst_mid asserted");
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b0;
      #1;
      chk(ov0, v_fwait, "rst_mid first cycle after release");
      step(0, 6'h23, 6'h00, 0, 0, v_fwait, "rst_mid fetch hold");

      // Random instruction stream against the model
      for (int n = 0; n < 150; n++) begin
         logic [5:0] ops[7];
         logic [5:0] fns[7];
         ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
         fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
         run_instr(0, ops[$urandom_range(0, 6)], fns[$urandom_range(0, 6)],
                   1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Illegal opcode with halt: one pulse, then parked with no enables
      do_reset();
      run_instr(0, 6'h3F, 6'h20, 0, 0, 0);
      for (int i = 0; i < 20; i++)
         step(0, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), v_halt,
              $sformatf("halt cyc%0d", i));

      // Illegal funct without halt: one pulse, then a normal instruction
      do_reset();
      run_instr(1, 6'h00, 6'h00, 0, 0, 0);
      run_instr(1, 6'h00, 6'h22, 0, 1, 0);
      run_instr(1, 6'h3F, 6'h00, 0, 0, 0);
      run_instr(1, 6'h08, 6'h00, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
